// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_pkg
// Description : Shared op-code constants, the muldiv FSM state type and small
//               operand helpers for the RV32M multiply/divide execute unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_unit_pkg;

    // Op-type codes shared with the ALU and the decoder
    localparam int unsigned OP_ADD    = 28;
    localparam int unsigned OP_MUL    = 38;
    localparam int unsigned OP_MULH   = 39;
    localparam int unsigned OP_MULHSU = 40;
    localparam int unsigned OP_MULHU  = 41;
    localparam int unsigned OP_DIV    = 42;
    localparam int unsigned OP_DIVU   = 43;
    localparam int unsigned OP_REM    = 44;
    localparam int unsigned OP_REMU   = 45;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } muldiv_state_e;

    // Top bit of an operand widened by one bit: copy of the sign when signed
    function automatic logic ext_msb(input logic msb, input logic is_signed);
        return is_signed & msb;
    endfunction

    function automatic logic is_mul_code(input logic [31:0] code);
        return (code >= OP_MUL) && (code <= OP_MULHU);
    endfunction

    function automatic logic is_div_code(input logic [31:0] code);
        return (code >= OP_DIV) && (code <= OP_REMU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_if
// Description : Issue (RS side) and completion (ROB side) signals of the
//               muldiv unit. master = RS/ROB, slave = the unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
    parameter int XLEN      = 32,
    parameter int ROB_IDX_W = 4,
    parameter int OP_W      = 6
);
    logic                 muldiv_mission;
    logic [OP_W-1:0]      muldiv_op_type;
    logic [XLEN-1:0]      muldiv_rs1;
    logic [XLEN-1:0]      muldiv_rs2;
    logic [ROB_IDX_W-1:0] muldiv_rob_dest;
    logic                 muldiv_busy;
    logic                 muldiv_finish;
    logic [ROB_IDX_W-1:0] muldiv_dest;
    logic [XLEN-1:0]      muldiv_out;

    modport master (
        output muldiv_mission, muldiv_op_type, muldiv_rs1, muldiv_rs2, muldiv_rob_dest,
        input  muldiv_busy, muldiv_finish, muldiv_dest, muldiv_out
    );

    modport slave (
        input  muldiv_mission, muldiv_op_type, muldiv_rs1, muldiv_rs2, muldiv_rob_dest,
        output muldiv_busy, muldiv_finish, muldiv_dest, muldiv_out
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit_div_core.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_div_core
// Description : Radix-2 restoring divider, one quotient bit per enabled cycle,
//               MSB first, on operand magnitudes with a sign fix-up applied
//               combinationally on the final iteration. done_o is a strobe in
//               the last iteration cycle with result_o valid alongside it.
//               Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed
//               overflow finish in the first cycle instead of iterating.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_div_core
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            rdy_i,
    input  wire logic            flush_i,
    input  wire logic            start_i,
    input  wire logic            is_signed_i,
    input  wire logic            want_rem_i,
    input  wire logic [XLEN-1:0] dividend_i,
    input  wire logic [XLEN-1:0] divisor_i,
    output logic                 done_o,
    output logic [XLEN-1:0]      result_o
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    logic             active_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  quo_q;       // dividend bits shifting out, quotient bits shifting in
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  dvs_q;
    logic [XLEN-1:0]  dividend_q;  // raw rs1, needed by the special-case results
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             want_rem_q;
    logic             div_zero_q;
    logic             ovf_q;

    logic            w_a_neg, w_b_neg, w_div_zero, w_ovf;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    logic [XLEN:0]   w_trial, w_diff;
    logic            w_fits;
    logic [XLEN-1:0] w_rem_n, w_quo_n, w_quo_res, w_rem_res;

    assign w_a_neg    = is_signed_i & dividend_i[XLEN-1];
    assign w_b_neg    = is_signed_i & divisor_i[XLEN-1];
    assign w_a_mag    = w_a_neg ? -dividend_i : dividend_i;
    assign w_b_mag    = w_b_neg ? -divisor_i  : divisor_i;
    assign w_div_zero = (divisor_i == '0);
    assign w_ovf      = is_signed_i && (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                        && (divisor_i == '1);

    // One restoring step: shift in the next dividend bit, subtract if it fits
    assign w_trial = {rem_q, quo_q[XLEN-1]};
    assign w_diff  = w_trial - {1'b0, dvs_q};
    assign w_fits  = ~w_diff[XLEN];
    assign w_rem_n = w_fits ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];
    assign w_quo_n = {quo_q[XLEN-2:0], w_fits};

    // Special cases override; otherwise apply the sign fix-up to the last step
    always_comb begin
        w_quo_res = neg_quo_q ? -w_quo_n : w_quo_n;
        w_rem_res = neg_rem_q ? -w_rem_n : w_rem_n;
        if (div_zero_q) begin
            w_quo_res = '1;
            w_rem_res = dividend_q;
        end else if (ovf_q) begin
            w_quo_res = dividend_q;
            w_rem_res = '0;
        end
    end

    assign result_o = want_rem_q ? w_rem_res : w_quo_res;

`ifdef DIV_EARLY_OUT_EN
    assign done_o = active_q && ((cnt_q == LAST_ITER) || div_zero_q || ovf_q);
`else
    assign done_o = active_q && (cnt_q == LAST_ITER);
`endif

    // Operand capture on start, then one iteration per enabled cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q   <= 1'b0;
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            dividend_q <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            want_rem_q <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (rdy_i) begin
            if (flush_i) begin
                active_q <= 1'b0;
            end else if (start_i) begin
                active_q   <= 1'b1;
                cnt_q      <= '0;
                quo_q      <= w_a_mag;
                rem_q      <= '0;
                dvs_q      <= w_b_mag;
                dividend_q <= dividend_i;
                neg_quo_q  <= w_a_neg ^ w_b_neg;
                neg_rem_q  <= w_a_neg;
                want_rem_q <= want_rem_i;
                div_zero_q <= w_div_zero;
                ovf_q      <= w_ovf;
            end else if (active_q) begin
                quo_q <= w_quo_n;
                rem_q <= w_rem_n;
                cnt_q <= cnt_q + CNT_W'(1);
                if (done_o) begin
                    active_q <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : RV32M multi-cycle execute unit. Multiplies run through a
//               MUL_STAGES deep pipeline, divides/remainders through the
//               iterative muldiv_div_core. One op in flight, busy back-pressure
//               to the RS, flush from the ROB, registered finish/dest/out.
//               Optional macro DIV_EARLY_OUT_EN shortens special-case divides.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ROB_IDX_W  = 4,
    parameter int OP_W       = 6,
    parameter int MUL_STAGES = 2
) (
    input  wire logic    clk,
    input  wire logic    rst,
    input  wire logic    rdy,
    input  wire logic    flush,
    muldiv_unit_if.slave bus
);
    localparam int PIPE_N = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
    localparam int CNT_W  = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'((MUL_STAGES > 1) ? MUL_STAGES - 2 : 0);

    muldiv_state_e        state_q, state_d;
    logic [OP_W-1:0]      op_q, op_d;
    logic [ROB_IDX_W-1:0] tag_q, tag_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 finish_q, finish_d;
    logic [ROB_IDX_W-1:0] dest_q, dest_d;
    logic [XLEN-1:0]      out_q, out_d;

    logic                 w_busy, w_is_mul, w_is_div, w_accept;
    logic                 w_a_signed, w_b_signed;
    logic [XLEN:0]        w_a_ext, w_b_ext;
    logic [2*XLEN-1:0]    w_a_wide, w_b_wide, w_prod, w_mul_tail;
    logic                 w_div_done;
    logic [XLEN-1:0]      w_div_result;

    function automatic logic [XLEN-1:0] mul_select(input logic [OP_W-1:0] op,
                                                   input logic [2*XLEN-1:0] prod);
        return (op == OP_W'(OP_MUL)) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    endfunction

    assign w_busy   = (state_q == S_MUL) || (state_q == S_DIV);
    assign w_is_mul = is_mul_code(32'(bus.muldiv_op_type));
    assign w_is_div = is_div_code(32'(bus.muldiv_op_type));
    assign w_accept = rdy && bus.muldiv_mission && !w_busy && !flush && !rst
                      && (w_is_mul || w_is_div);

    // rs1 is signed for everything but MULHU; rs2 only for MUL/MULH
    assign w_a_signed = (bus.muldiv_op_type != OP_W'(OP_MULHU));
    assign w_b_signed = (bus.muldiv_op_type == OP_W'(OP_MUL)) ||
                        (bus.muldiv_op_type == OP_W'(OP_MULH));
    assign w_a_ext = {ext_msb(bus.muldiv_rs1[XLEN-1], w_a_signed), bus.muldiv_rs1};
    assign w_b_ext = {ext_msb(bus.muldiv_rs2[XLEN-1], w_b_signed), bus.muldiv_rs2};
    // Only the low 2*XLEN product bits are ever returned, and these are exact
    // modulo 2^(2*XLEN) for the sign-extended XLEN+1 bit operands.
    assign w_a_wide = {{(XLEN-1){w_a_ext[XLEN]}}, w_a_ext};
    assign w_b_wide = {{(XLEN-1){w_b_ext[XLEN]}}, w_b_ext};
    assign w_prod   = w_a_wide * w_b_wide;

    generate
        if (MUL_STAGES > 1) begin : g_mul_pipe
            logic [2*XLEN-1:0] pipe_q [PIPE_N];
            // Product enters on the accept edge and advances each enabled cycle
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_N; i++) pipe_q[i] <= '0;
                end else if (rdy) begin
                    pipe_q[0] <= w_prod;
                    for (int i = 1; i < PIPE_N; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign w_mul_tail = pipe_q[PIPE_N-1];
        end else begin : g_mul_comb
            assign w_mul_tail = w_prod;
        end
    endgenerate

    muldiv_div_core #(
        .XLEN (XLEN)
    ) u_div_core (
        .clk         (clk),
        .rst         (rst),
        .rdy_i       (rdy),
        .flush_i     (flush),
        .start_i     (w_accept && w_is_div),
        .is_signed_i ((bus.muldiv_op_type == OP_W'(OP_DIV)) ||
                      (bus.muldiv_op_type == OP_W'(OP_REM))),
        .want_rem_i  ((bus.muldiv_op_type == OP_W'(OP_REM)) ||
                      (bus.muldiv_op_type == OP_W'(OP_REMU))),
        .dividend_i  (bus.muldiv_rs1),
        .divisor_i   (bus.muldiv_rs2),
        .done_o      (w_div_done),
        .result_o    (w_div_result)
    );

    // Next-state and registered-output decode; results only exist on finish
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        tag_d    = tag_q;
        cnt_d    = cnt_q;
        finish_d = 1'b0;
        dest_d   = '0;
        out_d    = '0;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_d = S_IDLE;
                    if (w_accept) begin
                        op_d  = bus.muldiv_op_type;
                        tag_d = bus.muldiv_rob_dest;
                        cnt_d = '0;
                        if (!w_is_mul) begin
                            state_d = S_DIV;
                        end else if (MUL_STAGES == 1) begin
                            state_d  = S_DONE;
                            finish_d = 1'b1;
                            dest_d   = bus.muldiv_rob_dest;
                            out_d    = mul_select(bus.muldiv_op_type, w_mul_tail);
                        end else begin
                            state_d = S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q == MUL_LAST) begin
                        state_d  = S_DONE;
                        finish_d = 1'b1;
                        dest_d   = tag_q;
                        out_d    = mul_select(op_q, w_mul_tail);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DIV: begin
                    if (w_div_done) begin
                        state_d  = S_DONE;
                        finish_d = 1'b1;
                        dest_d   = tag_q;
                        out_d    = w_div_result;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers; everything holds while rdy is low
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            tag_q    <= '0;
            cnt_q    <= '0;
            finish_q <= 1'b0;
            dest_q   <= '0;
            out_q    <= '0;
        end else if (rdy) begin
            state_q  <= state_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            cnt_q    <= cnt_d;
            finish_q <= finish_d;
            dest_q   <= dest_d;
            out_q    <= out_d;
        end
    end

    assign bus.muldiv_busy   = w_busy;
    assign bus.muldiv_finish = finish_q;
    assign bus.muldiv_dest   = dest_q;
    assign bus.muldiv_out    = out_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit. Expected results and
//               finish cycles are queued at issue and compared on finish.
//               Honours DIV_EARLY_OUT_EN for special-case divide latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int XLEN       = 32;
    localparam int ROB_IDX_W  = 4;
    localparam int OP_W       = 6;
    localparam int MUL_STAGES = 2;
    localparam int MUL_LAT    = MUL_STAGES;
    localparam int DIV_LAT    = XLEN + 1;
`ifdef DIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 2;
`else
    localparam int SPECIAL_LAT = DIV_LAT;
`endif

    typedef struct {
        logic [31:0] out;
        logic [3:0]  dest;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst, rdy, flush;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t e;

    muldiv_unit_if #(.XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W), .OP_W(OP_W)) bus ();

    muldiv_unit #(
        .XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W), .OP_W(OP_W), .MUL_STAGES(MUL_STAGES)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference RV32M semantics in 64-bit arithmetic
    function automatic logic [31:0] ref_result(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb64, ua, ub;
        logic [63:0] p;
        int ia, ib;
        sa = longint'(signed'(a));
        sb64 = longint'(signed'(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        ia = int'(a);
        ib = int'(b);
        p = 64'h0;
        case (op)
            38: begin p = 64'(sa * sb64); return p[31:0];  end
            39: begin p = 64'(sa * sb64); return p[63:32]; end
            40: begin p = 64'(sa * ub);   return p[63:32]; end
            41: begin p = 64'(ua * ub);   return p[63:32]; end
            42: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return 32'(ia / ib);
            end
            43: return (b == 0) ? 32'hFFFFFFFF : a / b;
            44: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input int op, input logic [31:0] a, input logic [31:0] b);
        if (op < 42) return MUL_LAT;
        if (b == 0) return SPECIAL_LAT;
        if ((op == 42 || op == 44) && a == 32'h80000000 && b == 32'hFFFFFFFF) return SPECIAL_LAT;
        return DIV_LAT;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        bus.muldiv_mission  = 1'b1;
        bus.muldiv_op_type  = OP_W'(op);
        bus.muldiv_rs1      = a;
        bus.muldiv_rs2      = b;
        bus.muldiv_rob_dest = tag;
    endtask

    task automatic expect_result(input logic [31:0] out, input logic [3:0] tag, input int at_cyc);
        exp_t x;
        x.out = out;
        x.dest = tag;
        x.cyc = at_cyc;
        sb.push_back(x);
    endtask

    // Issue one op in the current cycle and wait until it has completed
    task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, input logic [31:0] exp, input int lat);
        int k;
        k = cyc;
        issue(op, a, b, tag);
        expect_result(exp, tag, k + lat);
        step(1);
        bus.muldiv_mission = 1'b0;
        step(lat);
    endtask

    // Completion monitor: each rdy-enabled finish pops one expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.muldiv_finish && rdy) begin
                if (sb.size() == 0) begin
                    check_value("unexpected_finish", 32'(bus.muldiv_finish), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_value("result", bus.muldiv_out, e.out);
                    check_value("dest", 32'(bus.muldiv_dest), 32'(e.dest));
                    check_value("finish_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else if (!bus.muldiv_finish) begin
                check_value("idle_out", bus.muldiv_out, 32'd0);
            end
        end
    end

    initial begin
        int k;
        int op;
        logic [31:0] a, b;
        rst = 1'b1;
        rdy = 1'b1;
        flush = 1'b0;
        bus.muldiv_mission = 1'b0;
        bus.muldiv_op_type = '0;
        bus.muldiv_rs1 = '0;
        bus.muldiv_rs2 = '0;
        bus.muldiv_rob_dest = '0;
        step(3);
        check_value("rst_busy",   32'(bus.muldiv_busy),   32'd0);
        check_value("rst_finish", 32'(bus.muldiv_finish), 32'd0);
        check_value("rst_dest",   32'(bus.muldiv_dest),   32'd0);
        check_value("rst_out",    bus.muldiv_out,         32'd0);
        rst = 1'b0;
        step(1);

        // Multiplies
        run_op(OP_MUL,    32'd7,        32'hFFFFFFFD, 4'd3, 32'hFFFFFFEB, MUL_LAT);
        run_op(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 4'd5, 32'hFFFFFFFE, MUL_LAT);
        run_op(OP_MULH,   32'h80000000, 32'h80000000, 4'd6, 32'h40000000, MUL_LAT);
        run_op(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1, 32'hFFFFFFFF, MUL_LAT);

        // Signed divide with busy window
        k = cyc;
        issue(OP_DIV, 32'hFFFFFFEC, 32'd3, 4'd7);
        expect_result(32'hFFFFFFFA, 4'd7, k + DIV_LAT);
        check_value("busy_before", 32'(bus.muldiv_busy), 32'd0);
        step(1);
        bus.muldiv_mission = 1'b0;
        check_value("busy_first", 32'(bus.muldiv_busy), 32'd1);
        step(31);
        check_value("busy_last", 32'(bus.muldiv_busy), 32'd1);
        step(1);
        check_value("busy_done", 32'(bus.muldiv_busy), 32'd0);
        step(1);
        run_op(OP_REM, 32'hFFFFFFEC, 32'd3, 4'd8, 32'hFFFFFFFE, DIV_LAT);

        // Divide special cases and ordinary unsigned cases
        run_op(OP_DIVU, 32'd1234,     32'd0,        4'd2, 32'hFFFFFFFF, SPECIAL_LAT);
        run_op(OP_DIV,  32'hFFFFFFF9, 32'd0,        4'd4, 32'hFFFFFFFF, SPECIAL_LAT);
        run_op(OP_REM,  32'd5,        32'd0,        4'd9, 32'd5,        SPECIAL_LAT);
        run_op(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 4'd10, 32'h80000000, SPECIAL_LAT);
        run_op(OP_REM,  32'h80000000, 32'hFFFFFFFF, 4'd11, 32'd0,        SPECIAL_LAT);
        run_op(OP_REMU, 32'd100,      32'd7,        4'd12, 32'd2,        DIV_LAT);
        run_op(OP_DIVU, 32'hFFFFFFFF, 32'd2,        4'd13, 32'h7FFFFFFF, DIV_LAT);

        // Flush mid-divide, then an immediate multiply
        k = cyc;
        issue(OP_DIV, 32'd100, 32'd3, 4'd9);
        step(1);
        bus.muldiv_mission = 1'b0;
        step(9);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check_value("flush_busy", 32'(bus.muldiv_busy), 32'd0);
        run_op(OP_MUL, 32'd6, 32'd7, 4'd10, 32'd42, MUL_LAT);
        step(40);

        // rdy low for 5 cycles mid-divide
        k = cyc;
        issue(OP_DIV, 32'd1000, 32'hFFFFFFF9, 4'd11);
        expect_result(32'hFFFFFF72, 4'd11, k + DIV_LAT + 5);
        step(1);
        bus.muldiv_mission = 1'b0;
        step(9);
        rdy = 1'b0;
        step(2);
        check_value("frozen_busy", 32'(bus.muldiv_busy), 32'd1);
        step(3);
        rdy = 1'b1;
        step(DIV_LAT - 9 + 1);

        // Mission held while busy: second op taken only in the DONE cycle
        k = cyc;
        issue(OP_DIV, 32'd77, 32'd5, 4'd12);
        expect_result(32'd15, 4'd12, k + DIV_LAT);
        step(1);
        issue(OP_REM, 32'hFFFFFFB3, 32'd5, 4'd13);
        expect_result(32'hFFFFFFFE, 4'd13, k + 2 * DIV_LAT);
        step(DIV_LAT - 1);
        step(1);
        bus.muldiv_mission = 1'b0;
        step(DIV_LAT);

        // Non-muldiv op code with mission is ignored
        issue(OP_ADD, 32'd1, 32'd2, 4'd14);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_value("add_busy", 32'(bus.muldiv_busy), 32'd0);
        end
        bus.muldiv_mission = 1'b0;
        step(40);

        // Random mix against the reference model
        for (int i = 0; i < 16; i++) begin
            op = int'($urandom_range(38, 45));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            run_op(op, a, b, 4'(i), ref_result(op, a, b), latency(op, a, b));
        end

        step(5);
        check_value("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
